// File: rtl/elevator_pkg.sv
// Shared constants for the elevator request-handling blocks: serve direction
// encoding and default geometry / debounce depth.
package elevator_pkg;

   typedef enum logic [1:0] {
      SERVE_IDLE  = 2'b00,
      SERVE_UP    = 2'b01,
      SERVE_DOWN  = 2'b10,
      SERVE_CABIN = 2'b11
   } serve_dir_e;

   localparam int DEFAULT_LEVELS          = 8;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/btn_debounce.sv
// One raw button: 2-FF synchroniser, stability counter and a one-cycle pulse
// on the accepted 0->1 transition of the debounced level.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic rise
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1, sync2;
   logic          stable, stable_d;
   logic [CW-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would collapse the synchroniser chain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         stable   <= 1'b0;
         stable_d <= 1'b0;
         cnt      <= '0;
      end else begin
         sync1    <= btn;
         sync2    <= sync1;
         stable_d <= stable;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            stable <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign rise = stable & ~stable_d;

endmodule

// File: rtl/hall_call_registry.sv
// Latches cabin and hall requests from debounced buttons, clears them as the
// car serves floors, and summarises them relative to the current floor.
module hall_call_registry
   import elevator_pkg::*;
#(
   parameter  int LEVELS          = DEFAULT_LEVELS,
   parameter  int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   localparam int FLOOR_W         = $clog2(LEVELS),
   localparam int CNT_W           = $clog2(3*LEVELS+1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [LEVELS-1:0]  btn_in,
   input  logic [LEVELS-1:0]  btn_up_out,
   input  logic [LEVELS-1:0]  btn_down_out,
   input  logic [FLOOR_W-1:0] cur_floor,
   input  logic               serve_valid,
   input  logic [1:0]         serve_dir,
   output logic [LEVELS-1:0]  active_in_levels,
   output logic [LEVELS-1:0]  active_out_up_levels,
   output logic [LEVELS-1:0]  active_out_down_levels,
   output logic               req_above,
   output logic               req_below,
   output logic               req_here,
   output logic [CNT_W-1:0]   pending_count
);

   // No up call from the top floor, no down call from the bottom floor.
   localparam logic [LEVELS-1:0]  UP_MASK    = {1'b0, {(LEVELS-1){1'b1}}};
   localparam logic [LEVELS-1:0]  DOWN_MASK  = {{(LEVELS-1){1'b1}}, 1'b0};
   localparam logic [FLOOR_W:0]   LEVELS_LIM = (FLOOR_W+1)'(LEVELS);

   logic [LEVELS-1:0] in_rise, up_rise, down_rise;
   logic [LEVELS-1:0] floor_hot, above_mask, below_mask, all_req;
   logic [LEVELS-1:0] clr_in, clr_up, clr_down;
   logic              floor_ok;
   serve_dir_e        dir;

   for (genvar i = 0; i < LEVELS; i++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_in (
         .clk, .reset, .btn(btn_in[i]), .rise(in_rise[i]));
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
         .clk, .reset, .btn(btn_up_out[i] & UP_MASK[i]), .rise(up_rise[i]));
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
         .clk, .reset, .btn(btn_down_out[i] & DOWN_MASK[i]), .rise(down_rise[i]));
   end

   assign floor_ok = ({1'b0, cur_floor} < LEVELS_LIM);
   assign dir      = serve_dir_e'(serve_dir);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      floor_hot  = '0;
      above_mask = '0;
      below_mask = '0;
      for (int i = 0; i < LEVELS; i++) begin
         if (floor_ok) begin
            floor_hot[i]  = (FLOOR_W'(i) == cur_floor);
            above_mask[i] = (FLOOR_W'(i) >  cur_floor);
            below_mask[i] = (FLOOR_W'(i) <  cur_floor);
         end else begin
            below_mask[i] = 1'b1;
         end
      end
   end

   always_comb begin
      clr_in   = '0;
      clr_up   = '0;
      clr_down = '0;
      if (serve_valid) begin
         clr_in = floor_hot;
         case (dir)
            SERVE_IDLE: begin
               clr_up   = floor_hot;
               clr_down = floor_hot;
            end
            SERVE_UP:   clr_up   = floor_hot;
            SERVE_DOWN: clr_down = floor_hot;
            default:    ;
         endcase
      end
   end

   // A new request on the same edge as a serve of that floor survives.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active_in_levels       <= '0;
         active_out_up_levels   <= '0;
         active_out_down_levels <= '0;
      end else begin
         active_in_levels       <= (active_in_levels & ~clr_in) | in_rise;
         active_out_up_levels   <= ((active_out_up_levels & ~clr_up) | up_rise) & UP_MASK;
         active_out_down_levels <= ((active_out_down_levels & ~clr_down) | down_rise) & DOWN_MASK;
      end
   end

   assign all_req   = active_in_levels | active_out_up_levels | active_out_down_levels;
   assign req_above = |(all_req & above_mask);
   assign req_below = |(all_req & below_mask);
   assign req_here  = |(all_req & floor_hot);

   always_comb begin
      pending_count = '0;
      for (int i = 0; i < LEVELS; i++) begin
         pending_count = pending_count + CNT_W'(active_in_levels[i])
                       + CNT_W'(active_out_up_levels[i]) + CNT_W'(active_out_down_levels[i]);
      end
   end

endmodule
